alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Decode/operand-fetch stage directly upstream of the ALU. Accepts one 32-bit Beta instruction per handshake, decodes OP (register) and OPC (literal) class opcodes, and reads Ra/Rb from an internal 2-read/1-write register file. It resolves read-after-write hazards with a pending-write scoreboard. It presents opcode, operand A, operand B and destination to the ALU through a registered valid/ready output.

## Interface
- DWIDTH, 32, datapath and register width
- NREGS, 32, architectural registers; R31 reads as 0 and ignores writes
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction available
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  opcode[31:26], rc[25:21], ra[20:16], rb[15:11], lit[15:0]
- out_valid  out  1  operands valid for ALU
- out_ready  in  1  ALU consumes output this cycle
- out_opcode  out  6  opcode to ALU
- out_a  out  DWIDTH  value of Ra
- out_b  out  DWIDTH  value of Rb (OP) or sign-extended lit (OPC)
- out_rc  out  5  destination register
- out_illegal  out  1  opcode not a legal OP/OPC code
- wb_en  in  1  writeback strobe from ALU result path
- wb_addr  in  5  writeback register
- wb_data  in  DWIDTH  writeback value

## Operation
- Legal OP: 0x20–0x26, 0x28–0x2E; legal OPC: 0x30–0x36, 0x38–0x3E. Everything else is illegal.
- OP: out_b = RF[rb]. OPC: out_b = {{(DWIDTH-16){lit[15]}}, lit}. out_a = RF[ra] for both.
- Illegal: out_illegal=1, out_opcode passed through, out_a=out_b=0, out_rc=31, no scoreboard update.
- Register file: writes on wb_en when wb_addr!=31. Reads of index 31 return 0. Same-cycle write/read of the same index returns wb_data (write-through bypass).
- Scoreboard: pending[30:0].
  - Set pending[rc] on accept of a legal instruction with rc!=31.
  - Clear pending[wb_addr] on wb_en.
  - Same register set and cleared in one cycle: the set wins.
- Hazard: stall = in_valid && legal && (pending[ra] || (OP && pending[rb]) || pending[rc]), evaluated after the same-cycle wb_en clear. A source being written back this cycle does not stall.
- pending[31] is always 0.
- Accept = in_valid && in_ready, where in_ready = !stall && (!out_valid || out_ready).

## Timing
- Latency: instruction accepted on edge N appears at outputs after edge N (registered); throughput 1/cycle with no hazards.
- Output holds: while out_valid && !out_ready, all out_* stay stable and in_ready=0.
- Back-to-back dependent instructions (rc of first = ra of second): the second stalls until the cycle wb_en for that rc is high, then is accepted in that same cycle with bypassed data.
- Reset (any time, including mid-stall or with out_valid=1):
  - out_valid=0, out_opcode=0, out_a=0, out_b=0, out_rc=0, out_illegal=0.
  - pending=0, all RF entries=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - An instruction held at the output when reset asserts is discarded.
- wb_en is honoured even while the output is stalled.

## Structure
- Shared package beta_pkg: DWIDTH, opcode localparams (ADD…SRAC), instruction field positions, opclass_e enum {OP, OPC, ILLEGAL}, the decode function is_legal(opcode).
- Sub-module beta_regfile: 2R1W, async reset, R31 hard-zero, write-through bypass.
- Scoreboard and output register stay in the top-level module.

## Test plan
- Reset, then wb R1=5, R2=7; issue ADD R3,R1,R2 (0x20) -> next cycle out_valid=1, out_a=5, out_b=7, out_rc=3, pending[3]=1.
- ADDC R4,R1,0xFFFE (0x30) -> out_b=0xFFFFFFFE, out_a=5.
- ADD R3,R1,R2 then SUB R5,R3,R1 with no writeback -> in_ready=0 on SUB. Assert wb_en R3=12 -> SUB accepted that cycle; next cycle out_a=12, out_b=5.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. out_ready=1 -> the next instruction is accepted the same cycle.
- Opcode 0x27, then 0x18 -> out_illegal=1, out_a=out_b=0, out_rc=31, pending unchanged.
- Write R31=0xDEAD, read ADD R0,R31,R31 -> out_a=out_b=0. Assert rst while out_valid=1 -> out_valid=0, pending=0 immediately (asynchronous).

Source files
------------

// File: rtl/beta_pkg.sv
// Shared Beta ISA definitions: widths, opcodes, instruction field positions and
// the OP/OPC decode used by the operand-fetch stage.
package beta_pkg;

  localparam int DWIDTH = 32;
  localparam int NREGS  = 32;
  localparam int AWIDTH = 5;
  localparam int LWIDTH = 16;

  localparam logic [AWIDTH-1:0] R31 = 5'd31;

  // Instruction field positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RC_HI  = 25;
  localparam int RC_LO  = 21;
  localparam int RA_HI  = 20;
  localparam int RA_LO  = 16;
  localparam int RB_HI  = 15;
  localparam int RB_LO  = 11;
  localparam int LIT_HI = 15;
  localparam int LIT_LO = 0;

  // Register-register opcodes
  localparam logic [5:0] ADD   = 6'h20;
  localparam logic [5:0] SUB   = 6'h21;
  localparam logic [5:0] MUL   = 6'h22;
  localparam logic [5:0] DIV   = 6'h23;
  localparam logic [5:0] CMPEQ = 6'h24;
  localparam logic [5:0] CMPLT = 6'h25;
  localparam logic [5:0] CMPLE = 6'h26;
  localparam logic [5:0] AND   = 6'h28;
  localparam logic [5:0] OR    = 6'h29;
  localparam logic [5:0] XOR   = 6'h2A;
  localparam logic [5:0] XNOR  = 6'h2B;
  localparam logic [5:0] SHL   = 6'h2C;
  localparam logic [5:0] SHR   = 6'h2D;
  localparam logic [5:0] SRA   = 6'h2E;

  // Register-literal opcodes
  localparam logic [5:0] ADDC   = 6'h30;
  localparam logic [5:0] SUBC   = 6'h31;
  localparam logic [5:0] MULC   = 6'h32;
  localparam logic [5:0] DIVC   = 6'h33;
  localparam logic [5:0] CMPEQC = 6'h34;
  localparam logic [5:0] CMPLTC = 6'h35;
  localparam logic [5:0] CMPLEC = 6'h36;
  localparam logic [5:0] ANDC   = 6'h38;
  localparam logic [5:0] ORC    = 6'h39;
  localparam logic [5:0] XORC   = 6'h3A;
  localparam logic [5:0] XNORC  = 6'h3B;
  localparam logic [5:0] SHLC   = 6'h3C;
  localparam logic [5:0] SHRC   = 6'h3D;
  localparam logic [5:0] SRAC   = 6'h3E;

  typedef enum logic [1:0] {
    OP,
    OPC,
    ILLEGAL
  } opclass_e;

  typedef struct packed {
    logic [5:0]        opcode;
    opclass_e          cls;
    logic [AWIDTH-1:0] rc;
    logic [AWIDTH-1:0] ra;
    logic [AWIDTH-1:0] rb;
    logic [LWIDTH-1:0] lit;
  } decode_t;

  function automatic logic is_legal(input logic [5:0] opcode);
    return opcode inside {[ADD:CMPLE], [AND:SRA], [ADDC:CMPLEC], [ANDC:SRAC]};
  endfunction

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d.opcode = instr[OP_HI:OP_LO];
    d.rc     = instr[RC_HI:RC_LO];
    d.ra     = instr[RA_HI:RA_LO];
    d.rb     = instr[RB_HI:RB_LO];
    d.lit    = instr[LIT_HI:LIT_LO];
    if (!is_legal(d.opcode))  d.cls = ILLEGAL;
    else if (d.opcode[4])     d.cls = OPC;
    else                      d.cls = OP;
    return d;
  endfunction

endpackage

// File: rtl/beta_regfile.sv
// Two-read/one-write register file. R31 is not stored and always reads zero;
// a read of the register being written this cycle returns the write data.
module beta_regfile
  import beta_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] ra_addr,
  input  logic [AWIDTH-1:0] rb_addr,
  output logic [DWIDTH-1:0] ra_data,
  output logic [DWIDTH-1:0] rb_data,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata
);

  logic [DWIDTH-1:0] regs [NREGS-1];

  // NOTE: the whole array is cleared on reset because software relies on every
  // register reading zero afterwards; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
    end else if (we && waddr != R31) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data = '0;
    if (ra_addr != R31) ra_data = (we && waddr == ra_addr) ? wdata : regs[ra_addr];
  end

  always_comb begin
    rb_data = '0;
    if (rb_addr != R31) rb_data = (we && waddr == rb_addr) ? wdata : regs[rb_addr];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage ahead of the ALU: decodes OP/OPC instructions,
// reads operands, tracks pending writes and drives a registered valid/ready output.
module alu_operand_stage
  import beta_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [DWIDTH-1:0] out_a,
  output logic [DWIDTH-1:0] out_b,
  output logic [4:0]        out_rc,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DWIDTH-1:0] wb_data
);

  decode_t           dec;
  logic              legal;
  logic              is_op;
  logic [DWIDTH-1:0] ra_data;
  logic [DWIDTH-1:0] rb_data;

  logic [NREGS-2:0]  pending;
  logic [NREGS-1:0]  wb_clear;
  logic [NREGS-1:0]  live;
  logic [NREGS-2:0]  set_mask;
  logic              stall;
  logic              accept;

  logic [DWIDTH-1:0] nxt_a;
  logic [DWIDTH-1:0] nxt_b;
  logic [4:0]        nxt_rc;
  logic              nxt_illegal;

  assign dec   = decode(in_instr);
  assign legal = (dec.cls != ILLEGAL);
  assign is_op = (dec.cls == OP);

  beta_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (dec.ra),
    .rb_addr (dec.rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // The hazard check sees this cycle's writeback as already retired, matching
  // the register file bypass; bit 31 is never pending.
  assign wb_clear = wb_en ? (NREGS'(1) << wb_addr) : '0;
  assign live     = {1'b0, pending} & ~wb_clear;

  assign stall    = in_valid && legal &&
                    (live[dec.ra] || (is_op && live[dec.rb]) || live[dec.rc]);
  assign in_ready = !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign set_mask = (accept && legal && dec.rc != R31) ? ((NREGS-1)'(1) << dec.rc) : '0;

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= live[NREGS-2:0] | set_mask;
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a value unassigned and infers a latch.
  always_comb begin
    nxt_a       = '0;
    nxt_b       = '0;
    nxt_rc      = R31;
    nxt_illegal = 1'b1;
    unique case (dec.cls)
      OP: begin
        nxt_a       = ra_data;
        nxt_b       = rb_data;
        nxt_rc      = dec.rc;
        nxt_illegal = 1'b0;
      end
      OPC: begin
        nxt_a       = ra_data;
        nxt_b       = {{(DWIDTH-LWIDTH){dec.lit[LWIDTH-1]}}, dec.lit};
        nxt_rc      = dec.rc;
        nxt_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_rc      <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_opcode  <= dec.opcode;
      out_a       <= nxt_a;
      out_b       <= nxt_b;
      out_rc      <= nxt_rc;
      out_illegal <= nxt_illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, hand-written
// hazard/backpressure/reset sequences and randomized traffic against a reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rc;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rc      (out_rc),
    .out_illegal (out_illegal),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register values, pending-write flags and
  // the word currently held for the ALU.
  logic [31:0] rf_m [32];
  bit          pend_m [32];
  bit          ov_m;
  bit          ill_m;
  logic [5:0]  op_m;
  logic [31:0] a_m;
  logic [31:0] b_m;
  logic [4:0]  rc_m;
  bit          ready_seen;

  function automatic bit legal_m(input logic [5:0] op);
    return op inside {[6'h20:6'h26], [6'h28:6'h2E], [6'h30:6'h36], [6'h38:6'h3E]};
  endfunction

  function automatic bit waits_on(input logic [4:0] r, input bit we, input logic [4:0] wa);
    return (r != 5'd31) && pend_m[r] && !(we && wa == r);
  endfunction

  function automatic logic [31:0] src(input logic [4:0] r, input bit we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd31)        return 32'h0;
    if (we && wa == r)     return wd;
    return rf_m[r];
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 31; i++) v[i] = pend_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      rf_m[i]   = '0;
      pend_m[i] = 1'b0;
    end
    ov_m = 0; ill_m = 0; op_m = '0; a_m = '0; b_m = '0; rc_m = '0;
  endtask

  task automatic compare_outputs();
    check("out_valid", 32'(out_valid), 32'(ov_m));
    check("pending", 32'(dut.pending), pend_vec());
    if (ov_m) begin
      check("out_opcode", 32'(out_opcode), 32'(op_m));
      check("out_a", out_a, a_m);
      check("out_b", out_b, b_m);
      check("out_rc", 32'(out_rc), 32'(rc_m));
      check("out_illegal", 32'(out_illegal), 32'(ill_m));
    end
  endtask

  // One clock cycle: drive just after a falling edge, check in_ready, step the
  // model across the rising edge, then compare outputs on the next falling edge.
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0]  op;
    logic [4:0]  rc, ra, rb;
    logic [15:0] lit;
    bit          lg, is_op, busy, exp_ready, acc;
    logic [31:0] va, vb;
    op  = ins[31:26];
    rc  = ins[25:21];
    ra  = ins[20:16];
    rb  = ins[15:11];
    lit = ins[15:0];
    in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    lg        = legal_m(op);
    is_op     = lg && (op < 6'h30);
    busy      = waits_on(ra, we, wa) || (is_op && waits_on(rb, we, wa)) || waits_on(rc, we, wa);
    exp_ready = !(iv && lg && busy) && (!ov_m || ordy);
    acc       = iv && exp_ready;
    va        = src(ra, we, wa, wd);
    vb        = is_op ? src(rb, we, wa, wd) : {{16{lit[15]}}, lit};
    #1;
    ready_seen = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (acc) begin
      ov_m = 1; op_m = op;
      if (lg) begin a_m = va;  b_m = vb;  rc_m = rc;    ill_m = 0; end
      else    begin a_m = '0;  b_m = '0;  rc_m = 5'd31; ill_m = 1; end
    end else if (ordy) begin
      ov_m = 0;
    end
    if (we) begin
      pend_m[wa] = 1'b0;
      if (wa != 5'd31) rf_m[wa] = wd;
    end
    if (acc && lg && rc != 5'd31) pend_m[rc] = 1'b1;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle();
    cycle(0, 32'h0, 1, 0, 5'd0, 32'h0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    cycle(0, 32'h0, 1, 1, a, d);
  endtask

  task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rc, input bit ill);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".a"}, out_a, a);
    check({name, ".b"}, out_b, b);
    check({name, ".rc"}, 32'(out_rc), 32'(rc));
    check({name, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  function automatic logic [31:0] op_i(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'b0};
  endfunction

  function automatic logic [31:0] opc_i(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rc;
    bit          ill;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{"add",     op_i(6'h20, 5'd3, 5'd1, 5'd2),           6'h20, 32'd5, 32'd7,         5'd3,  0};
    vt[1] = '{"addc",    opc_i(6'h30, 5'd4, 5'd1, 16'hFFFE),      6'h30, 32'd5, 32'hFFFFFFFE,  5'd4,  0};
    vt[2] = '{"subc",    opc_i(6'h31, 5'd8, 5'd2, 16'h7FFF),      6'h31, 32'd7, 32'h00007FFF,  5'd8,  0};
    vt[3] = '{"add_r31", op_i(6'h20, 5'd0, 5'd31, 5'd31),         6'h20, 32'd0, 32'd0,         5'd0,  0};
    vt[4] = '{"ill_27",  op_i(6'h27, 5'd12, 5'd1, 5'd2),          6'h27, 32'd0, 32'd0,         5'd31, 1};
    vt[5] = '{"ill_18",  op_i(6'h18, 5'd13, 5'd1, 5'd2),          6'h18, 32'd0, 32'd0,         5'd31, 1};
    vt[6] = '{"sra",     op_i(6'h2E, 5'd9, 5'd2, 5'd1),           6'h2E, 32'd7, 32'd5,         5'd9,  0};
    vt[7] = '{"srac",    opc_i(6'h3E, 5'd10, 5'd31, 16'h8000),    6'h3E, 32'd0, 32'hFFFF8000,  5'd10, 0};
    vt[8] = '{"ill_37",  opc_i(6'h37, 5'd14, 5'd1, 16'h0001),     6'h37, 32'd0, 32'd0,         5'd31, 1};
    vt[9] = '{"cmple",   op_i(6'h26, 5'd11, 5'd1, 5'd1),          6'h26, 32'd5, 32'd5,         5'd11, 0};

    rst = 1; in_valid = 0; in_instr = '0; out_ready = 1;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_a", out_a, 32'd0);
    check("rst.out_b", out_b, 32'd0);
    check("rst.out_rc", 32'(out_rc), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    rst = 0;

    // Directed vector table
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    wb(5'd31, 32'hDEAD);
    for (int i = 0; i < 10; i++) begin
      cycle(1, vt[i].instr, 1, 0, 5'd0, 32'h0);
      check({vt[i].name, ".accept"}, 32'(ready_seen), 32'd1);
      check({vt[i].name, ".opcode"}, 32'(out_opcode), 32'(vt[i].op));
      expect_out(vt[i].name, vt[i].a, vt[i].b, vt[i].rc, vt[i].ill);
    end
    check("pend_r3_set", 32'(dut.pending[3]), 32'd1);
    check("pend_illegal_untouched", 32'(dut.pending[14:12]), 32'd0);

    // Asynchronous reset while a word is held and writes are pending
    #2 rst = 1;
    #1;
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.pending", 32'(dut.pending), 32'd0);
    check("async_rst.out_a", out_a, 32'd0);
    check("async_rst.out_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    cycle(1, op_i(6'h20, 5'd0, 5'd1, 5'd2), 1, 0, 5'd0, 32'h0);
    check("post_rst.ready", 32'(ready_seen), 32'd1);
    check("post_rst.rf_cleared", out_a, 32'd0);

    // Read-after-write hazard resolved by same-cycle writeback
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    cycle(1, op_i(6'h20, 5'd3, 5'd1, 5'd2), 1, 0, 5'd0, 32'h0);
    check("raw.add_accept", 32'(ready_seen), 32'd1);
    repeat (2) begin
      cycle(1, op_i(6'h21, 5'd5, 5'd3, 5'd1), 1, 0, 5'd0, 32'h0);
      check("raw.sub_stall", 32'(ready_seen), 32'd0);
    end
    cycle(1, op_i(6'h21, 5'd5, 5'd3, 5'd1), 1, 1, 5'd3, 32'd12);
    check("raw.sub_accept_on_wb", 32'(ready_seen), 32'd1);
    expect_out("raw.sub", 32'd12, 32'd5, 5'd5, 0);

    // Output backpressure
    idle();
    cycle(1, op_i(6'h20, 5'd6, 5'd1, 5'd2), 1, 0, 5'd0, 32'h0);
    repeat (3) begin
      cycle(1, opc_i(6'h30, 5'd7, 5'd1, 16'h0001), 0, 0, 5'd0, 32'h0);
      check("bp.in_ready_low", 32'(ready_seen), 32'd0);
      expect_out("bp.hold", 32'd5, 32'd7, 5'd6, 0);
    end
    cycle(1, opc_i(6'h30, 5'd7, 5'd1, 16'h0001), 1, 0, 5'd0, 32'h0);
    check("bp.release_accept", 32'(ready_seen), 32'd1);
    expect_out("bp.next", 32'd5, 32'd1, 5'd7, 0);

    // Randomized traffic against the model
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [5:0]  op;
      logic [4:0]  rc, ra, wa;
      logic [15:0] lit;
      if ($urandom_range(0, 9) < 8)
        op = {1'b1, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 6))};
      else
        op = 6'($urandom);
      rc  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      wa  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      lit = 16'($urandom);
      cycle($urandom_range(0, 4) != 0, {op, rc, ra, lit}, $urandom_range(0, 3) != 0,
            1'($urandom), wa, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
